// File: rtl/serial_cmp_di.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : serial_cmp_di
// Purpose  : Bit-serial, LSB-first unsigned magnitude comparator.
//            Two W-bit operands are latched on a start pulse and walked one
//            bit per clock through the right-to-left comparator cell
//              N = n&(~A|B) | ~A&B
//            whose carry n is held in a register. After W bits the final
//            carry is the strict less-than result lt = (a < b).
//
// Parameters:
//   W       operand width in bits (W >= 2), default 8
//
// Ports:
//   clk     in   1  rising-edge clock
//   rst_n   in   1  asynchronous active-low reset
//   start   in   1  request, only honoured while idle
//   a       in   W  operand A, captured on the accepting edge
//   b       in   W  operand B, captured on the accepting edge
//   busy    out  1  high while an operation is running or completing
//   done    out  1  one-cycle pulse, lt/eq valid
//   lt      out  1  registered result, 1 iff a < b (unsigned)
//   eq      out  1  registered result, 1 iff a == b (CMP_EQ_EN builds only)
//
// Build options:
//   CMP_EQ_EN  when defined, adds the eq output and its running equality
//              register. lt/busy/done timing is identical either way.
//
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module serial_cmp_di #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic         lt
`ifdef CMP_EQ_EN
  ,
  output logic         eq
`endif
);

  // Bit counter only has to reach W-1; guard the degenerate width anyway.
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  localparam logic [CW-1:0] c_LAST = CW'(W - 1);
  localparam logic [CW-1:0] c_ONE  = CW'(1);
  localparam logic [CW-1:0] c_ZERO = '0;

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]    r_state;
  logic [W-1:0]  r_sa;
  logic [W-1:0]  r_sb;
  logic          r_n;
  logic [CW-1:0] r_cnt;
  logic          r_lt;

  logic w_aBit;
  logic w_bBit;
  logic w_nNext;
  logic w_accept;
  logic w_run;
  logic w_lastBit;

  assign w_aBit    = r_sa[0];
  assign w_bBit    = r_sb[0];

  // Comparator cell: a bit where A<B sets n, A>B clears it, equal bits
  // pass the lower-order verdict upward. The most significant differing
  // bit therefore has the last word.
  assign w_nNext   = (r_n & (~w_aBit | w_bBit)) | (~w_aBit & w_bBit);

  assign w_accept  = (r_state == c_IDLE) && start;
  assign w_run     = (r_state == c_RUN);
  assign w_lastBit = w_run && (r_cnt == c_LAST);

  //----------------------------------------------------------------------------
  // Control FSM and datapath. start is ignored outside IDLE, so a request
  // held high simply restarts once the previous result has been presented.
  //----------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_n     <= 1'b0;
      r_cnt   <= c_ZERO;
      r_lt    <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (start) begin
            r_sa    <= a;
            r_sb    <= b;
            r_n     <= 1'b0;
            r_cnt   <= c_ZERO;
            r_state <= c_RUN;
          end
        end

        c_RUN: begin
          r_n  <= w_nNext;
          r_sa <= r_sa >> 1;
          r_sb <= r_sb >> 1;
          if (w_lastBit) begin
            // Result is taken from the cell output, not r_n, so it includes
            // the MSB consumed on this very edge.
            r_lt    <= w_nNext;
            r_cnt   <= c_ZERO;
            r_state <= c_DONE;
          end else begin
            r_cnt <= r_cnt + c_ONE;
          end
        end

        c_DONE: begin
          r_state <= c_IDLE;
        end

        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign busy = (r_state != c_IDLE);
  assign done = (r_state == c_DONE);
  assign lt   = r_lt;

`ifdef CMP_EQ_EN
  //----------------------------------------------------------------------------
  // Running equality: starts true and is knocked out by any differing bit.
  //----------------------------------------------------------------------------
  logic r_e;
  logic r_eq;
  logic w_eNext;

  assign w_eNext = r_e & ~(w_aBit ^ w_bBit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e  <= 1'b0;
      r_eq <= 1'b0;
    end else begin
      if (w_accept) begin
        r_e <= 1'b1;
      end else if (w_run) begin
        r_e <= w_eNext;
      end
      if (w_lastBit) begin
        r_eq <= w_eNext;
      end
    end
  end

  assign eq = r_eq;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_cmp_di.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_serial_cmp_di
// Purpose  : Self-checking bench for serial_cmp_di (W=8). Directed cases plus
//            a random sweep; expected results come from plain unsigned
//            comparison of the operands, and expected timing from the
//            accept / W run edges / one done cycle sequence.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module tb_serial_cmp_di;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] opA;
  logic [W-1:0] opB;
  logic         busy;
  logic         done;
  logic         lt;
`ifdef CMP_EQ_EN
  logic         eq;
`endif

  int total = 0;
  int bad   = 0;

  // Last completed result, which lt/eq must hold while a new operation runs.
  logic holdLt = 1'b0;
  logic holdEq = 1'b0;

  serial_cmp_di #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (opA),
    .b     (opB),
    .busy  (busy),
    .done  (done),
    .lt    (lt)
`ifdef CMP_EQ_EN
    ,
    .eq    (eq)
`endif
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full operation with timing checks. scramble: drive junk on a/b and
  // pulse start while busy, both of which must have no effect.
  task automatic doOp(input logic [W-1:0] va, input logic [W-1:0] vb, input bit scramble);
    logic expLt;
    logic expEq;
    expLt = (va < vb);
    expEq = (va == vb);
    start = 1'b1;
    opA   = va;
    opB   = vb;
    tick();                                  // accepting edge
    start = 1'b0;
    chk("busy_after_accept", busy, 1'b1);
    chk("lt_held_in_run", lt, holdLt);
`ifdef CMP_EQ_EN
    chk("eq_held_in_run", eq, holdEq);
`endif
    for (int i = 1; i < W; i++) begin
      if (scramble) begin
        opA   = W'($urandom);
        opB   = W'($urandom);
        start = (i < W - 1) ? 1'($urandom) : 1'b0;
      end
      tick();
      chk("done_early", done, 1'b0);
      chk("busy_in_run", busy, 1'b1);
    end
    start = 1'b0;
    tick();                                  // W-th run edge
    chk("done_pulse", done, 1'b1);
    chk("busy_in_done", busy, 1'b1);
    chk("lt_result", lt, expLt);
`ifdef CMP_EQ_EN
    chk("eq_result", eq, expEq);
`endif
    tick();
    chk("done_one_cycle", done, 1'b0);
    chk("busy_back_idle", busy, 1'b0);
    chk("lt_hold_after", lt, expLt);
    holdLt = expLt;
    holdEq = expEq;
  endtask

  initial begin
    int doneCnt;
    int firstDone;
    int secondDone;

    // Reset state
    rst_n = 1'b0;
    start = 1'b0;
    opA   = '0;
    opB   = '0;
    tick();
    tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_lt", lt, 1'b0);
`ifdef CMP_EQ_EN
    chk("rst_eq", eq, 1'b0);
`endif
    rst_n = 1'b1;
    tick();
    chk("idle_busy", busy, 1'b0);

    // Basic less-than
    doOp(8'h05, 8'h09, 1'b0);
    // Equal operands, then greater
    doOp(8'hA3, 8'hA3, 1'b0);
    doOp(8'hFF, 8'h00, 1'b0);
    // MSB outweighs all lower bits
    doOp(8'h7F, 8'h80, 1'b0);
    doOp(8'h80, 8'h7F, 1'b0);
    // Extremes and LSB-only differences
    doOp(8'h00, 8'hFF, 1'b0);
    doOp(8'h00, 8'h00, 1'b0);
    doOp(8'hFE, 8'hFF, 1'b0);
    doOp(8'hFF, 8'hFE, 1'b0);

    // start held high: a new operation every W+2 cycles
    start      = 1'b1;
    opA        = 8'd3;
    opB        = 8'd4;
    doneCnt    = 0;
    firstDone  = -1;
    secondDone = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (done === 1'b1) begin
        doneCnt++;
        if (firstDone < 0) firstDone = k;
        else if (secondDone < 0) secondDone = k;
      end
    end
    start = 1'b0;
    tick();
    chk("held_start_pulses", doneCnt, 2);
    chk("held_start_spacing", secondDone - firstDone, W + 2);
    chk("held_start_lt", lt, 1'b1);
    holdLt = 1'b1;
    holdEq = 1'b0;

    // Operands and start toggled mid-run must be ignored
    doOp(8'd3, 8'd4, 1'b1);

    // Asynchronous reset in the middle of a run
    start = 1'b1;
    opA   = 8'h09;
    opB   = 8'h01;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("pre_rst_busy", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_done", done, 1'b0);
    chk("async_rst_lt", lt, 1'b0);
`ifdef CMP_EQ_EN
    chk("async_rst_eq", eq, 1'b0);
`endif
    tick();
    rst_n  = 1'b1;
    holdLt = 1'b0;
    holdEq = 1'b0;
    tick();
    chk("post_rst_idle", busy, 1'b0);
    doOp(8'd1, 8'd2, 1'b0);

    // Random sweep; every other operation also scrambles inputs mid-run
    for (int r = 0; r < 1000; r++) begin
      doOp(W'($urandom), W'($urandom), 1'(r & 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
